// File: rtl/eq_dispatcher_pkg.sv
// Shared definitions for the event-queue dispatcher: queue op encoding and FSM states.
// No logic of its own.
package eq_dispatcher_pkg;

  localparam logic READ_OP = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_CHECK = 3'd2,
    S_POP   = 3'd3,
    S_OUT   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/eq_dispatcher.sv
// Pops every event at cur_time from the heap and hands it out on valid/ready; advances time when the step drains.
// ev_valid 3 cycles after q_dv && !q_busy; an unaccepted event holds the FSM in OUT and issues no further pops.
module eq_dispatcher
  import eq_dispatcher_pkg::*;
#(
  parameter int DATA_WD = 16,
  parameter int TIME_WD = 8,
  parameter int ID_WD   = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [TIME_WD-1:0] i_t0,
  input  logic [DATA_WD-1:0] i_q_ev,
  input  logic               i_q_dv,
  input  logic               i_q_busy,
  input  logic               i_q_empty,
  output logic               o_q_cs,
  output logic               o_q_op,
  input  logic               i_ins_pend,
  output logic               o_ev_valid,
  input  logic               i_ev_ready,
  output logic [ID_WD-1:0]   o_ev_id,
  output logic [TIME_WD-1:0] o_ev_time,
  output logic [TIME_WD-1:0] o_cur_time,
  output logic               o_time_adv,
  output logic               o_done,
  output logic               o_caus_err
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [TIME_WD-1:0] r_cur_time;
  logic [TIME_WD-1:0] w_cur_nxt;
  logic               r_caus_err;
  logic               w_caus_nxt;
  logic               r_time_adv;
  logic               w_adv_nxt;
  logic [ID_WD-1:0]   r_ev_id;
  logic [TIME_WD-1:0] r_ev_time;
  logic               w_pop;
  logic [TIME_WD-1:0] w_top_t;

  assign w_top_t = i_q_ev[DATA_WD-1 -: TIME_WD];
  // Heap reorganising after a write can still be in flight when POP is reached; hold the read off.
  assign w_pop   = (r_state == S_POP) && !i_q_busy;

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur_time;
    w_caus_nxt  = r_caus_err;
    w_adv_nxt   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_cur_nxt   = i_t0;
          w_caus_nxt  = 1'b0;
          w_state_nxt = S_WAIT;
        end else if (r_state == S_DONE && (i_ins_pend || !i_q_empty)) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_q_busy || i_ins_pend) w_state_nxt = S_WAIT;
        else if (i_q_empty)         w_state_nxt = S_DONE;
        else if (i_q_dv)            w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        // A pending insert may land at cur_time, so it must be seen before comparing again.
        if (i_ins_pend || i_q_busy || !i_q_dv) begin
          w_state_nxt = S_WAIT;
        end else if (w_top_t == r_cur_time) begin
          w_state_nxt = S_POP;
        end else if (w_top_t > r_cur_time) begin
          w_cur_nxt = w_top_t;
          w_adv_nxt = 1'b1;
        end else begin
          w_caus_nxt  = 1'b1;
          w_state_nxt = S_POP;
        end
      end
      S_POP: begin
        if (w_pop) w_state_nxt = S_OUT;
      end
      S_OUT: begin
        if (i_ev_ready) w_state_nxt = S_WAIT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= S_IDLE;
      r_cur_time <= '0;
      r_caus_err <= 1'b0;
      r_time_adv <= 1'b0;
      r_ev_id    <= '0;
      r_ev_time  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cur_time <= w_cur_nxt;
      r_caus_err <= w_caus_nxt;
      r_time_adv <= w_adv_nxt;
      if (w_pop) begin
        r_ev_id   <= i_q_ev[ID_WD-1:0];
        r_ev_time <= w_top_t;
      end
    end
  end

  assign o_q_cs     = w_pop;
  assign o_q_op     = w_pop ? READ_OP : 1'b0;
  assign o_ev_valid = (r_state == S_OUT);
  assign o_ev_id    = r_ev_id;
  assign o_ev_time  = r_ev_time;
  assign o_cur_time = r_cur_time;
  assign o_time_adv = r_time_adv;
  assign o_done     = (r_state == S_DONE);
  assign o_caus_err = r_caus_err;

endmodule

// File: tb/tb_eq_dispatcher.sv
// Bench for eq_dispatcher: a small sorted-heap model with busy timing stands in for the Queue.
// Single-event vectors from a table, plus hand sequences for reset, ordering, backpressure, ins_pend and empty start.
module tb_eq_dispatcher;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  t0 = '0;
  logic [15:0] q_ev;
  logic        q_dv, q_busy, q_empty, q_cs, q_op;
  logic        ins_pend = 1'b0;
  logic        ev_valid;
  logic        ev_ready = 1'b1;
  logic [7:0]  ev_id, ev_time, cur_time;
  logic        time_adv, done, caus_err;

  logic        ins_vld = 1'b0;
  logic [15:0] ins_dat = '0;
  logic        mon_clr = 1'b0;

  always #5 clk = ~clk;

  eq_dispatcher #(.DATA_WD(16), .TIME_WD(8), .ID_WD(8)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_start(start), .i_t0(t0),
    .i_q_ev(q_ev), .i_q_dv(q_dv), .i_q_busy(q_busy), .i_q_empty(q_empty),
    .o_q_cs(q_cs), .o_q_op(q_op), .i_ins_pend(ins_pend),
    .o_ev_valid(ev_valid), .i_ev_ready(ev_ready),
    .o_ev_id(ev_id), .o_ev_time(ev_time), .o_cur_time(cur_time),
    .o_time_adv(time_adv), .o_done(done), .o_caus_err(caus_err)
  );

  // Queue model: stable sort by time, busy for 2 cycles after a pop and 1 after an insert.
  logic [15:0] hq[$];
  int          bcnt;
  int          m_pos;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hq.delete();
      bcnt = 0;
      q_ev    <= '0;
      q_empty <= 1'b1;
      q_busy  <= 1'b0;
      q_dv    <= 1'b0;
    end else begin
      if (bcnt > 0) bcnt = bcnt - 1;
      if (q_cs && q_op && hq.size() > 0) begin
        void'(hq.pop_front());
        bcnt = 2;
      end
      if (ins_vld) begin
        m_pos = hq.size();
        for (int i = 0; i < hq.size(); i++) begin
          if (hq[i][15:8] > ins_dat[15:8]) begin
            m_pos = i;
            break;
          end
        end
        hq.insert(m_pos, ins_dat);
        if (bcnt < 1) bcnt = 1;
      end
      q_busy  <= (bcnt != 0);
      q_empty <= (hq.size() == 0);
      q_ev    <= (hq.size() > 0) ? hq[0] : 16'h0;
      q_dv    <= (hq.size() > 0) && (bcnt == 0);
    end
  end

  // Monitor: handshakes, time advances and read-side protocol, sampled on the falling edge.
  logic [15:0] got[$];
  logic [7:0]  adv_log[$];
  int          prot_err = 0;
  logic        prev_cs = 1'b0;
  always @(negedge clk) begin
    if (mon_clr) begin
      got.delete();
      adv_log.delete();
      prev_cs = 1'b0;
    end else begin
      if (ev_valid && ev_ready) got.push_back({ev_time, ev_id});
      if (time_adv) adv_log.push_back(cur_time);
      if (q_cs && q_busy) prot_err++;
      if (q_cs && prev_cs) prot_err++;
      prev_cs = q_cs;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0; start = 1'b0; ins_pend = 1'b0; ins_vld = 1'b0; ev_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic insert(input logic [15:0] d);
    ins_vld = 1'b1;
    ins_dat = d;
    tick();
    ins_vld = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] t);
    repeat (4) tick();
    t0 = t;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_done"}, {31'd0, seen}, 32'd1);
  endtask

  typedef struct {
    logic [7:0]  t0;
    logic [15:0] ev;
    logic [15:0] exp_ev;
    logic        exp_caus;
    int          exp_adv;
    logic [7:0]  exp_cur;
  } vec_t;

  vec_t vt[6];

  initial begin
    logic        seen;
    logic        hold_ok;
    logic [15:0] e;

    vt[0] = '{t0: 8'h00, ev: 16'h0011, exp_ev: 16'h0011, exp_caus: 1'b0, exp_adv: 0, exp_cur: 8'h00};
    vt[1] = '{t0: 8'h05, ev: 16'h0301, exp_ev: 16'h0301, exp_caus: 1'b1, exp_adv: 0, exp_cur: 8'h05};
    vt[2] = '{t0: 8'h00, ev: 16'hFF22, exp_ev: 16'hFF22, exp_caus: 1'b0, exp_adv: 1, exp_cur: 8'hFF};
    vt[3] = '{t0: 8'h07, ev: 16'h0933, exp_ev: 16'h0933, exp_caus: 1'b0, exp_adv: 1, exp_cur: 8'h09};
    vt[4] = '{t0: 8'hFF, ev: 16'hFF44, exp_ev: 16'hFF44, exp_caus: 1'b0, exp_adv: 0, exp_cur: 8'hFF};
    vt[5] = '{t0: 8'h80, ev: 16'h10AB, exp_ev: 16'h10AB, exp_caus: 1'b1, exp_adv: 0, exp_cur: 8'h80};

    #1;
    check("rst_q_cs", {31'd0, q_cs}, 32'd0);
    check("rst_q_op", {31'd0, q_op}, 32'd0);
    check("rst_ev_valid", {31'd0, ev_valid}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_cur_time", {24'd0, cur_time}, 32'd0);
    check("rst_caus_time_adv", {30'd0, caus_err, time_adv}, 32'd0);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      insert(vt[v].ev);
      pulse_start(vt[v].t0);
      wait_done($sformatf("vec%0d", v));
      check($sformatf("vec%0d_count", v), got.size(), 32'd1);
      e = (got.size() > 0) ? got[0] : 16'hxxxx;
      check($sformatf("vec%0d_event", v), {16'd0, e}, {16'd0, vt[v].exp_ev});
      check($sformatf("vec%0d_caus", v), {31'd0, caus_err}, {31'd0, vt[v].exp_caus});
      check($sformatf("vec%0d_adv", v), adv_log.size(), vt[v].exp_adv);
      check($sformatf("vec%0d_cur", v), {24'd0, cur_time}, {24'd0, vt[v].exp_cur});
    end

    // Reset while a read is being issued
    do_reset();
    insert(16'h0305);
    pulse_start(8'h03);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (q_cs) begin
        seen = 1'b1;
        break;
      end
    end
    check("midpop_cs_seen", {31'd0, seen}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midpop_q_cs", {31'd0, q_cs}, 32'd0);
    check("midpop_outs", {27'd0, ev_valid, done, time_adv, caus_err, q_op}, 32'd0);
    check("midpop_cur", {24'd0, cur_time}, 32'd0);
    #3;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midpop_idle", {30'd0, ev_valid, done}, 32'd0);

    // Ordering across several time steps
    do_reset();
    insert(16'h02A1);
    insert(16'h0010);
    insert(16'h02A2);
    insert(16'h0555);
    pulse_start(8'h00);
    wait_done("order");
    check("order_count", got.size(), 32'd4);
    if (got.size() == 4) begin
      check("order_ev0", {16'd0, got[0]}, 32'h0010);
      check("order_ev1", {16'd0, got[1]}, 32'h02A1);
      check("order_ev2", {16'd0, got[2]}, 32'h02A2);
      check("order_ev3", {16'd0, got[3]}, 32'h0555);
    end
    check("order_adv_count", adv_log.size(), 32'd2);
    if (adv_log.size() == 2) begin
      check("order_adv0", {24'd0, adv_log[0]}, 32'd2);
      check("order_adv1", {24'd0, adv_log[1]}, 32'd5);
    end
    check("order_caus", {31'd0, caus_err}, 32'd0);

    // Backpressure: consumer stalls for 10 cycles
    do_reset();
    insert(16'h0166);
    ev_ready = 1'b0;
    pulse_start(8'h01);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ev_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("bp_valid_seen", {31'd0, seen}, 32'd1);
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!ev_valid || ev_id !== 8'h66 || q_cs) hold_ok = 1'b0;
    end
    check("bp_hold", {31'd0, hold_ok}, 32'd1);
    tick();
    ev_ready = 1'b1;
    tick();
    @(negedge clk);
    check("bp_valid_fall", {31'd0, ev_valid}, 32'd0);
    wait_done("bp");
    check("bp_count", got.size(), 32'd1);

    // Zero-delay insert while the inserter holds ins_pend
    do_reset();
    insert(16'h02A1);
    insert(16'h0555);
    pulse_start(8'h02);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ev_valid && ev_ready) break;
    end
    ins_pend = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    check("pend_cur_held", {24'd0, cur_time}, 32'd2);
    check("pend_no_adv", adv_log.size(), 32'd0);
    tick();
    insert(16'h0277);
    ins_pend = 1'b0;
    wait_done("pend");
    check("pend_count", got.size(), 32'd3);
    if (got.size() == 3) begin
      check("pend_ev1", {16'd0, got[1]}, 32'h0277);
      check("pend_ev2", {16'd0, got[2]}, 32'h0555);
    end
    check("pend_cur_final", {24'd0, cur_time}, 32'd5);

    // Start with nothing queued
    do_reset();
    repeat (3) tick();
    t0 = 8'h09;
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("empty_done", {31'd0, seen}, 32'd1);
    check("empty_adv", adv_log.size(), 32'd0);
    check("empty_cur", {24'd0, cur_time}, 32'd9);

    check("read_protocol", prot_err, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
